// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline, divider and VPU scalar results onto the single
// regfile write port, and tracks outstanding long-latency writes in a busy scoreboard.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_wb_en_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        div_valid_i,
  input  logic [4:0]  div_rd_i,
  input  logic [31:0] div_data_i,
  output logic        div_ready_o,
  input  logic        vpu_valid_i,
  input  logic [4:0]  vpu_rd_i,
  input  logic [31:0] vpu_data_i,
  output logic        vpu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  output logic [31:0] busy_o,
  output logic        stall_o,
  output logic        wb_en_o,
  output logic [4:0]  rd_index_o,
  output logic [31:0] rd_data_o
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    SRC_DIV = 1'b0,
    SRC_VPU = 1'b1
  } late_src_e;

  late_src_e        r_last_grant;
  logic [CNT_W-1:0] r_div_cnt;
  logic [CNT_W-1:0] r_vpu_cnt;
  logic             r_stall;
  logic [31:0]      r_busy;
  logic             r_wb_en;
  logic [4:0]       r_rd_index;
  logic [31:0]      r_rd_data;

  logic             w_pipe_present;
  logic             w_div_hs;
  logic             w_vpu_hs;
  logic             w_win;
  logic [4:0]       w_win_rd;
  logic [31:0]      w_win_data;
  logic [CNT_W-1:0] w_div_cnt_nxt;
  logic [CNT_W-1:0] w_vpu_cnt_nxt;
  logic             w_stall_nxt;
  logic [31:0]      w_busy_nxt;

  // Rd==0 pipe requests do not occupy the port; the late sources may use that slot.
  assign w_pipe_present = pipe_wb_en_i && (pipe_rd_i != 5'd0);

  // Ties go to the source not granted last; reset is gated in so ready is low during reset.
  assign w_div_hs = !rst_i && !w_pipe_present && div_valid_i &&
                    (!vpu_valid_i || (r_last_grant == SRC_VPU));
  assign w_vpu_hs = !rst_i && !w_pipe_present && vpu_valid_i &&
                    (!div_valid_i || (r_last_grant == SRC_DIV));

  assign div_ready_o = w_div_hs;
  assign vpu_ready_o = w_vpu_hs;

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_win      = 1'b0;
    w_win_rd   = pipe_rd_i;
    w_win_data = pipe_data_i;
    if (w_pipe_present) begin
      w_win = 1'b1;
    end else if (w_div_hs) begin
      w_win      = 1'b1;
      w_win_rd   = div_rd_i;
      w_win_data = div_data_i;
    end else if (w_vpu_hs) begin
      w_win      = 1'b1;
      w_win_rd   = vpu_rd_i;
      w_win_data = vpu_data_i;
    end
  end

  always_comb begin
    w_div_cnt_nxt = '0;
    w_vpu_cnt_nxt = '0;
    if (div_valid_i && !w_div_hs) begin
      w_div_cnt_nxt = (r_div_cnt == CNT_MAX) ? r_div_cnt : r_div_cnt + 1'b1;
    end
    if (vpu_valid_i && !w_vpu_hs) begin
      w_vpu_cnt_nxt = (r_vpu_cnt == CNT_MAX) ? r_vpu_cnt : r_vpu_cnt + 1'b1;
    end
    w_stall_nxt = ((r_div_cnt == CNT_MAX) && div_valid_i && !w_div_hs) ||
                  ((r_vpu_cnt == CNT_MAX) && vpu_valid_i && !w_vpu_hs);
  end

  // Set is applied after clear so an issue and a completion to the same index leave it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_div_hs) w_busy_nxt[div_rd_i] = 1'b0;
    if (w_vpu_hs) w_busy_nxt[vpu_rd_i] = 1'b0;
    if (issue_i)  w_busy_nxt[issue_rd_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= SRC_VPU;
      r_div_cnt    <= '0;
      r_vpu_cnt    <= '0;
      r_stall      <= 1'b0;
    end else begin
      if (w_div_hs) begin
        r_last_grant <= SRC_DIV;
      end else if (w_vpu_hs) begin
        r_last_grant <= SRC_VPU;
      end
      r_div_cnt <= w_div_cnt_nxt;
      r_vpu_cnt <= w_vpu_cnt_nxt;
      r_stall   <= w_stall_nxt;
    end
  end

  // NOTE: the scoreboard is 32 flops, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Index and data hold between writes; only the enable pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_en    <= 1'b0;
      r_rd_index <= 5'd0;
      r_rd_data  <= 32'd0;
    end else begin
      r_wb_en <= w_win && (w_win_rd != 5'd0);
      if (w_win) begin
        r_rd_index <= w_win_rd;
        r_rd_data  <= w_win_data;
      end
    end
  end

  assign busy_o     = r_busy;
  assign stall_o    = r_stall;
  assign wb_en_o    = r_wb_en;
  assign rd_index_o = r_rd_index;
  assign rd_data_o  = r_rd_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the writeback rules.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pipe_wb_en_i = 1'b0;
  logic [4:0]  pipe_rd_i = '0;
  logic [31:0] pipe_data_i = '0;
  logic        div_valid_i = 1'b0;
  logic [4:0]  div_rd_i = '0;
  logic [31:0] div_data_i = '0;
  logic        div_ready_o;
  logic        vpu_valid_i = 1'b0;
  logic [4:0]  vpu_rd_i = '0;
  logic [31:0] vpu_data_i = '0;
  logic        vpu_ready_o;
  logic        issue_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [31:0] busy_o;
  logic        stall_o;
  logic        wb_en_o;
  logic [4:0]  rd_index_o;
  logic [31:0] rd_data_o;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pipe_wb_en_i (pipe_wb_en_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .div_valid_i  (div_valid_i),
    .div_rd_i     (div_rd_i),
    .div_data_i   (div_data_i),
    .div_ready_o  (div_ready_o),
    .vpu_valid_i  (vpu_valid_i),
    .vpu_rd_i     (vpu_rd_i),
    .vpu_data_i   (vpu_data_i),
    .vpu_ready_o  (vpu_ready_o),
    .issue_i      (issue_i),
    .issue_rd_i   (issue_rd_i),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .wb_en_o      (wb_en_o),
    .rd_index_o   (rd_index_o),
    .rd_data_o    (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit        m_wb_en;
  bit [4:0]  m_idx;
  bit [31:0] m_data;
  bit [31:0] m_busy;
  bit        m_stall;
  bit        m_div_granted_last;
  int        m_div_wait;
  int        m_vpu_wait;

  bit s_div_hs;
  bit s_vpu_hs;
  int div_age;
  int vpu_age;

  task automatic model_reset();
    m_wb_en = 0; m_idx = 0; m_data = 0; m_busy = 0; m_stall = 0;
    m_div_granted_last = 0;
    m_div_wait = 0; m_vpu_wait = 0;
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic cycle();
    bit pp, dr, vr, stall_next;
    #1;
    pp = pipe_wb_en_i && (pipe_rd_i != 0);
    dr = 0; vr = 0;
    if (!pp) begin
      if (div_valid_i && vpu_valid_i) begin
        if (m_div_granted_last) vr = 1; else dr = 1;
      end else if (div_valid_i) dr = 1;
      else if (vpu_valid_i) vr = 1;
    end
    check("div_ready", div_ready_o, dr);
    check("vpu_ready", vpu_ready_o, vr);
    s_div_hs = div_valid_i && div_ready_o;
    s_vpu_hs = vpu_valid_i && vpu_ready_o;

    if (pp) begin
      m_wb_en = 1; m_idx = pipe_rd_i; m_data = pipe_data_i;
    end else if (dr) begin
      m_wb_en = (div_rd_i != 0); m_idx = div_rd_i; m_data = div_data_i;
    end else if (vr) begin
      m_wb_en = (vpu_rd_i != 0); m_idx = vpu_rd_i; m_data = vpu_data_i;
    end else begin
      m_wb_en = 0;
    end

    stall_next = (div_valid_i && !dr && m_div_wait == LIMIT) ||
                 (vpu_valid_i && !vr && m_vpu_wait == LIMIT);
    m_stall = stall_next;
    m_div_wait = (div_valid_i && !dr) ? ((m_div_wait < LIMIT) ? m_div_wait + 1 : LIMIT) : 0;
    m_vpu_wait = (vpu_valid_i && !vr) ? ((m_vpu_wait < LIMIT) ? m_vpu_wait + 1 : LIMIT) : 0;

    if (dr) m_busy[div_rd_i] = 0;
    if (vr) m_busy[vpu_rd_i] = 0;
    if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1;

    if (dr) m_div_granted_last = 1;
    else if (vr) m_div_granted_last = 0;

    @(posedge clk_i);
    @(negedge clk_i);
    check("wb_en", wb_en_o, m_wb_en);
    check("rd_index", rd_index_o, m_idx);
    check("rd_data", rd_data_o, m_data);
    check("busy", busy_o, m_busy);
    check("stall", stall_o, m_stall);
  endtask

  task automatic idle_inputs();
    pipe_wb_en_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
    div_valid_i = 0; vpu_valid_i = 0; issue_i = 0; issue_rd_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
  endtask

  task automatic new_div();
    div_valid_i = 1; div_rd_i = 5'($urandom); div_data_i = $urandom; div_age = 0;
  endtask

  task automatic new_vpu();
    vpu_valid_i = 1; vpu_rd_i = 5'($urandom); vpu_data_i = $urandom; vpu_age = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with late sources valid during reset.
    div_valid_i = 1; vpu_valid_i = 1;
    #1 rst_i = 1;
    #3;
    check("rst_div_ready", div_ready_o, 0);
    check("rst_vpu_ready", vpu_ready_o, 0);
    check("rst_wb_en", wb_en_o, 0);
    check("rst_rd_index", rd_index_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_stall", stall_o, 0);
    @(negedge clk_i);
    do_reset();

    // Pipe-only writes, including one to x0.
    pipe_wb_en_i = 1; pipe_rd_i = 5; pipe_data_i = 32'hDEADBEEF;
    cycle();
    check("pipe_wb_en", wb_en_o, 1);
    check("pipe_idx", rd_index_o, 5);
    check("pipe_data", rd_data_o, 32'hDEADBEEF);
    pipe_rd_i = 0; pipe_data_i = 32'h12345678;
    cycle();
    check("pipe_x0_wb_en", wb_en_o, 0);
    idle_inputs();

    // Pipe beats the divider; divider lands once the pipe goes idle.
    pipe_wb_en_i = 1; pipe_rd_i = 3; pipe_data_i = 32'h33;
    div_valid_i = 1; div_rd_i = 7; div_data_i = 32'h77;
    cycle();
    check("cont_div_blocked", s_div_hs, 0);
    check("cont_pipe_idx", rd_index_o, 3);
    pipe_wb_en_i = 0;
    cycle();
    check("cont_div_granted", s_div_hs, 1);
    check("cont_div_idx", rd_index_o, 7);
    check("cont_div_data", rd_data_o, 32'h77);
    idle_inputs();

    // Round-robin from reset: div, vpu, div, vpu.
    do_reset();
    div_valid_i = 1; div_rd_i = 1; div_data_i = 32'hD1;
    vpu_valid_i = 1; vpu_rd_i = 2; vpu_data_i = 32'hE2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_grant", s_div_hs ? 0 : (s_vpu_hs ? 1 : 2), i % 2);
    end
    idle_inputs();

    // Scoreboard set, clear, set-wins-over-clear, x0 never busy.
    issue_i = 1; issue_rd_i = 10;
    cycle();
    check("sb_set10", busy_o[10], 1);
    issue_i = 0; div_valid_i = 1; div_rd_i = 10; div_data_i = 32'hA;
    cycle();
    check("sb_clr10", busy_o[10], 0);
    issue_i = 1; issue_rd_i = 10;
    cycle();
    check("sb_set_wins", busy_o[10], 1);
    issue_i = 0;
    cycle();
    issue_i = 1; issue_rd_i = 0; div_valid_i = 0;
    cycle();
    check("sb_x0", busy_o[0], 0);
    idle_inputs();

    // Starvation: pipe every cycle while VPU waits, then contract violation, then release.
    vpu_valid_i = 1; vpu_rd_i = 9; vpu_data_i = 32'h99;
    for (int i = 0; i < LIMIT + 1; i++) begin
      pipe_wb_en_i = 1; pipe_rd_i = 5'(i + 1); pipe_data_i = $urandom;
      cycle();
      if (i == LIMIT - 1) check("starve_not_yet", stall_o, 0);
    end
    check("starve_stall", stall_o, 1);
    pipe_rd_i = 20; pipe_data_i = 32'hCAFE;
    cycle();
    check("starve_pipe_wins", rd_index_o, 20);
    check("starve_vpu_blocked", s_vpu_hs, 0);
    check("starve_stall_hold", stall_o, 1);
    pipe_wb_en_i = 0;
    cycle();
    check("starve_vpu_granted", s_vpu_hs, 1);
    check("starve_stall_drop", stall_o, 0);
    idle_inputs();

    // Asynchronous reset while a write is on the port.
    issue_i = 1; issue_rd_i = 12;
    pipe_wb_en_i = 1; pipe_rd_i = 6; pipe_data_i = 32'h66;
    cycle();
    check("mid_wb_en_pre", wb_en_o, 1);
    idle_inputs();
    rst_i = 1;
    #1;
    check("mid_wb_en", wb_en_o, 0);
    check("mid_rd_index", rd_index_o, 0);
    check("mid_rd_data", rd_data_o, 0);
    check("mid_busy", busy_o, 0);
    check("mid_stall", stall_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    model_reset();

    // Randomized traffic; the pipe honours stall_o so grant latency is bounded.
    for (int c = 0; c < 2000; c++) begin
      if (!stall_o && ($urandom_range(2, 0) != 0)) begin
        pipe_wb_en_i = 1; pipe_rd_i = 5'($urandom); pipe_data_i = $urandom;
      end else begin
        pipe_wb_en_i = 0; pipe_rd_i = 5'($urandom); pipe_data_i = $urandom;
      end
      issue_i = ($urandom_range(3, 0) == 0);
      issue_rd_i = 5'($urandom);
      cycle();
      if (s_div_hs) check("div_latency", (div_age <= LIMIT + 2) ? 1 : 0, 1);
      if (s_vpu_hs) check("vpu_latency", (vpu_age <= LIMIT + 2) ? 1 : 0, 1);
      if (s_div_hs) begin
        div_valid_i = 0;
        if ($urandom_range(1, 0) == 1) new_div();
      end else if (div_valid_i) div_age++;
      else if ($urandom_range(2, 0) == 0) new_div();
      if (s_vpu_hs) begin
        vpu_valid_i = 0;
        if ($urandom_range(1, 0) == 1) new_vpu();
      end else if (vpu_valid_i) vpu_age++;
      else if ($urandom_range(2, 0) == 0) new_vpu();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
